// File: rtl/cdec_pkg.sv
// Shared CDEC definitions: PLA control-word field positions, memory command
// codes, special opcodes and the control-sequencer top-FSM encoding.
package cdec_pkg;

    localparam int unsigned CDEC_STATE_W = 4;
    localparam int unsigned CDEC_MAX_STEP = 15;
    localparam int unsigned PLA_W = 18;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned FLAG_W = 3;

    // Control-word field positions
    localparam int unsigned PLA_END = 17;
    localparam int unsigned PLA_MEM_HI = 16;
    localparam int unsigned PLA_MEM_LO = 15;
    localparam int unsigned PLA_FLAG_EN = 14;

    // Memory command codes carried in pla[PLA_MEM_HI:PLA_MEM_LO]
    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_WRITE = 2'b01;
    localparam logic [1:0] MEM_READ = 2'b10;

    localparam logic [DATA_W-1:0] OPC_HLT = 8'hFF;
    localparam int unsigned IR_LOAD_STEP = 2;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_EXEC    = 2'd1,
        SEQ_MEMWAIT = 2'd2,
        SEQ_HALTED  = 2'd3
    } seq_state_t;

    // True for a command that needs a memory handshake; 2'b11 counts as none
    function automatic logic is_mem_cmd(input logic [1:0] cmd);
        logic hit;
        case (cmd)
            MEM_READ, MEM_WRITE: hit = 1'b1;
            MEM_NONE:            hit = 1'b0;
            default:             hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ctrl_seq.sv
// CDEC control sequencer: micro-step counter, instruction and flag registers
// feeding the control PLA, memory-step stretching and run/halt control.
// Optional single-step support is built when CTRL_SEQ_STEP_EN is defined.
module ctrl_seq
    import cdec_pkg::*;
#(
    parameter int unsigned STATE_W = CDEC_STATE_W,
    parameter logic [STATE_W-1:0] MAX_STEP = STATE_W'(CDEC_MAX_STEP)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                step,
    input  logic [PLA_W-1:0]    pla,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [FLAG_W-1:0]   alu_flag,
    input  logic                mem_ack,
    output logic [STATE_W-1:0]  state,
    output logic [DATA_W-1:0]   instruction,
    output logic [FLAG_W-1:0]   flag,
    output logic                cpu_en,
    output logic                mem_req,
    output logic                mem_we,
    output logic                halted,
    output logic                illegal
);

    seq_state_t          fsm_q;
    seq_state_t          fsm_d;
    logic [STATE_W-1:0]  state_d;
    logic [DATA_W-1:0]   instr_d;
    logic [FLAG_W-1:0]   flag_d;
    logic                mem_req_d;
    logic                mem_we_d;
    logic                halted_d;
    logic                illegal_d;
    logic                mem_first_q;
    logic                mem_first_d;
    logic                run_q;
    logic                ss_q;
    logic                step_go_c;
    logic [1:0]          mem_cmd_c;
    logic                mem_op_c;
    logic                boundary_c;
    logic                overrun_c;
    logic                unused_pla;

    assign mem_cmd_c = pla[PLA_MEM_HI:PLA_MEM_LO];
    assign mem_op_c = is_mem_cmd(mem_cmd_c);
    assign boundary_c = cpu_en && pla[PLA_END];
    assign overrun_c = cpu_en && !pla[PLA_END] && (state == MAX_STEP);
    assign unused_pla = ^pla[13:0];

`ifdef CTRL_SEQ_STEP_EN
    assign step_go_c = step;

    // Single-step flag: armed by a step pulse while stopped, cleared on halt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_q <= 1'b0;
        end else if (halted && step) begin
            ss_q <= 1'b1;
        end else if (fsm_d == SEQ_HALTED) begin
            ss_q <= 1'b0;
        end
    end
`else
    logic unused_step;

    assign step_go_c = 1'b0;
    assign ss_q = 1'b0;
    assign unused_step = step;
`endif

    // Datapath update enable: plain EXEC steps, or the acknowledged memory cycle
    always_comb begin
        cpu_en = ((fsm_q == SEQ_EXEC) && !mem_op_c) ||
                 ((fsm_q == SEQ_MEMWAIT) && mem_ack && !mem_first_q);
    end

    // Next-state and next-register decode
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state;
        instr_d     = instruction;
        flag_d      = flag;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        illegal_d   = illegal;
        mem_first_d = 1'b0;

        if (cpu_en) begin
            state_d = pla[PLA_END] ? '0 : state + STATE_W'(1);
            if (state == STATE_W'(IR_LOAD_STEP)) begin
                instr_d = data_in;
            end
            if (pla[PLA_FLAG_EN]) begin
                flag_d = alu_flag;
            end
        end

        case (fsm_q)
            SEQ_IDLE, SEQ_HALTED: begin
                state_d = '0;
                if (step_go_c || (run && !run_q)) begin
                    fsm_d = SEQ_EXEC;
                end
            end
            SEQ_EXEC: begin
                if (mem_op_c) begin
                    fsm_d       = SEQ_MEMWAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = pla[PLA_MEM_LO];
                    mem_first_d = 1'b1;
                end
            end
            SEQ_MEMWAIT: begin
                if (cpu_en) begin
                    fsm_d     = SEQ_EXEC;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                fsm_d = SEQ_IDLE;
            end
        endcase

        // A step past MAX_STEP without an end bit is an illegal decode
        if (overrun_c) begin
            illegal_d = 1'b1;
            fsm_d     = SEQ_HALTED;
            state_d   = '0;
        end else if (boundary_c && (!run || ss_q || (instruction == OPC_HLT))) begin
            fsm_d = SEQ_HALTED;
        end

        halted_d = (fsm_d == SEQ_IDLE) || (fsm_d == SEQ_HALTED);
    end

    // Sequencer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= SEQ_IDLE;
            state       <= '0;
            instruction <= '0;
            flag        <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            halted      <= 1'b1;
            illegal     <= 1'b0;
            mem_first_q <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state       <= state_d;
            instruction <= instr_d;
            flag        <= flag_d;
            mem_req     <= mem_req_d;
            mem_we      <= mem_we_d;
            halted      <= halted_d;
            illegal     <= illegal_d;
            mem_first_q <= mem_first_d;
            run_q       <= run;
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq with a behavioural PLA stub, a memory
// responder and scoreboards for IR loads, flag loads and memory requests.
module tb_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        step;
    logic [17:0] pla;
    logic [7:0]  data_in;
    logic [2:0]  alu_flag;
    logic        mem_ack;
    logic [3:0]  state;
    logic [7:0]  instruction;
    logic [2:0]  flag;
    logic        cpu_en;
    logic        mem_req;
    logic        mem_we;
    logic        halted;
    logic        illegal;

    int tests_run = 0;
    int tests_failed = 0;

    int          ack_delay = 1;
    int          req_cnt = 0;
    int          req_len = 0;
    logic        prev_req = 1'b0;
    logic [7:0]  prev_ir = 8'h00;
    logic [2:0]  prev_flag = 3'b000;
    logic [7:0]  model_ir = 8'h00;
    logic [2:0]  model_flag = 3'b000;
    logic        never_end = 1'b0;

    int          exp_len_q[$];
    logic        exp_we_q[$];
    logic [7:0]  exp_ir_q[$];
    logic [2:0]  exp_flag_q[$];

    always #5 clk = ~clk;

    ctrl_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .step        (step),
        .pla         (pla),
        .data_in     (data_in),
        .alu_flag    (alu_flag),
        .mem_ack     (mem_ack),
        .state       (state),
        .instruction (instruction),
        .flag        (flag),
        .cpu_en      (cpu_en),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .halted      (halted),
        .illegal     (illegal)
    );

    // PLA stub: step 1 reads the opcode, step 3 ends; 05 latches flags,
    // 44 performs a write on its last step. never_end gives an all-zero word.
    function automatic logic [17:0] pla_stub(input logic [3:0] s, input logic [7:0] ir,
                                             input logic ne);
        logic [17:0] w;
        w = '0;
        w[12:0] = {1'b0, s, ir};
        if (!ne) begin
            case (s)
                4'd1: w[16:15] = 2'b10;
                4'd3: begin
                    w[17] = 1'b1;
                    if (ir == 8'h05) w[14] = 1'b1;
                    if (ir == 8'h44) w[16:15] = 2'b01;
                end
                default: ;
            endcase
        end
        return w;
    endfunction

    assign pla = pla_stub(state, instruction, never_end);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_ir(input logic [7:0] v);
        if (v !== model_ir) begin
            exp_ir_q.push_back(v);
            model_ir = v;
        end
    endtask

    task automatic expect_flag(input logic [2:0] v);
        if (v !== model_flag) begin
            exp_flag_q.push_back(v);
            model_flag = v;
        end
    endtask

    task automatic expect_mem(input logic we);
        exp_len_q.push_back(ack_delay + 1);
        exp_we_q.push_back(we);
    endtask

    // One clock: sample outputs after the edge, score events, drive mem_ack
    task automatic tick();
        logic       ew;
        int         el;
        logic [7:0] ei;
        logic [2:0] ef;
        @(posedge clk);
        #1;
        if (mem_req && !prev_req) begin
            tests_run++;
            req_len = 0;
            if (exp_we_q.size() == 0) begin
                tests_failed++;
                $display("FAIL mem_start: unexpected request, mem_we=%0b", mem_we);
            end else begin
                ew = exp_we_q.pop_front();
                if (mem_we !== ew) begin
                    tests_failed++;
                    $display("FAIL mem_we: got %0b, expected %0b", mem_we, ew);
                end
            end
        end
        if (mem_req) req_len++;
        if (!mem_req && prev_req) begin
            tests_run++;
            if (exp_len_q.size() == 0) begin
                tests_failed++;
                $display("FAIL mem_len: unexpected request of %0d cycles", req_len);
            end else begin
                el = exp_len_q.pop_front();
                if (req_len != el) begin
                    tests_failed++;
                    $display("FAIL mem_len: mem_req high %0d cycles, expected %0d", req_len, el);
                end
            end
        end
        if (instruction !== prev_ir) begin
            tests_run++;
            if (exp_ir_q.size() == 0) begin
                tests_failed++;
                $display("FAIL ir_load: unexpected instruction %02h", instruction);
            end else begin
                ei = exp_ir_q.pop_front();
                if (instruction !== ei) begin
                    tests_failed++;
                    $display("FAIL ir_load: instruction %02h, expected %02h", instruction, ei);
                end
            end
        end
        if (flag !== prev_flag) begin
            tests_run++;
            if (exp_flag_q.size() == 0) begin
                tests_failed++;
                $display("FAIL flag_load: unexpected flag %03b", flag);
            end else begin
                ef = exp_flag_q.pop_front();
                if (flag !== ef) begin
                    tests_failed++;
                    $display("FAIL flag_load: flag %03b, expected %03b", flag, ef);
                end
            end
        end
        prev_req  = mem_req;
        prev_ir   = instruction;
        prev_flag = flag;
        if (mem_req) req_cnt++;
        else req_cnt = 0;
        mem_ack = mem_req && (req_cnt == ack_delay + 1);
    endtask

    task automatic run_until_halt(input int drop_tick, input int exp_tick, input string name);
        int t = 0;
        do begin
            tick();
            t++;
            if (t == drop_tick) run = 1'b0;
        end while (!halted && t < 100);
        tests_run++;
        if (t != exp_tick) begin
            tests_failed++;
            $display("FAIL %s: halted after %0d cycles, expected %0d", name, t, exp_tick);
        end
    endtask

    task automatic check_drained(input string name);
        tests_run++;
        if (exp_ir_q.size() != 0 || exp_flag_q.size() != 0 ||
            exp_len_q.size() != 0 || exp_we_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drained: pending ir=%0d flag=%0d mem=%0d, expected 0", name,
                     exp_ir_q.size(), exp_flag_q.size(), exp_len_q.size());
        end
        exp_ir_q.delete();
        exp_flag_q.delete();
        exp_len_q.delete();
        exp_we_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run = 1'b0;
        step = 1'b0;
        data_in = 8'h00;
        alu_flag = 3'b000;
        mem_ack = 1'b0;
        never_end = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run += 8;
        if (state !== 4'd0) begin tests_failed++; $display("FAIL reset_state: %0d, expected 0", state); end
        if (instruction !== 8'h00) begin tests_failed++; $display("FAIL reset_ir: %02h, expected 00", instruction); end
        if (flag !== 3'b000) begin tests_failed++; $display("FAIL reset_flag: %03b, expected 000", flag); end
        if (cpu_en !== 1'b0) begin tests_failed++; $display("FAIL reset_cpu_en: %0b, expected 0", cpu_en); end
        if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: %0b, expected 0", mem_req); end
        if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_we: %0b, expected 0", mem_we); end
        if (halted !== 1'b1) begin tests_failed++; $display("FAIL reset_halted: %0b, expected 1", halted); end
        if (illegal !== 1'b0) begin tests_failed++; $display("FAIL reset_illegal: %0b, expected 0", illegal); end
        @(negedge clk);
        rst_n = 1'b1;
        req_cnt = 0;
        prev_req = 1'b0;
        prev_ir = 8'h00;
        prev_flag = 3'b000;
        model_ir = 8'h00;
        model_flag = 3'b000;
    endtask

    task automatic test_fetch();
        ack_delay = 2;
        data_in = 8'h05;
        alu_flag = 3'b101;
        expect_mem(1'b0);
        expect_ir(8'h05);
        expect_flag(3'b101);
        run = 1'b1;
        run_until_halt(7, 8, "fetch_halt_tick");
        tests_run += 2;
        if (state !== 4'd0) begin tests_failed++; $display("FAIL fetch_state: %0d, expected 0", state); end
        if (flag !== 3'b101) begin tests_failed++; $display("FAIL fetch_flag: %03b, expected 101", flag); end
        check_drained("fetch");
    endtask

    task automatic test_run_drop();
        ack_delay = 2;
        data_in = 8'h44;
        expect_mem(1'b0);
        expect_ir(8'h44);
        expect_mem(1'b1);
        run = 1'b1;
        run_until_halt(2, 11, "run_drop_halt_tick");
        tests_run++;
        if (state !== 4'd0 || mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL run_drop_idle: state=%0d mem_req=%0b, expected 0/0", state, mem_req);
        end
        check_drained("run_drop");
    endtask

    task automatic test_hlt();
        logic bad = 1'b0;
        ack_delay = 1;
        data_in = 8'hFF;
        expect_mem(1'b0);
        expect_ir(8'hFF);
        run = 1'b1;
        run_until_halt(0, 7, "hlt_halt_tick");
        repeat (6) begin
            tick();
            if (state !== 4'd0 || halted !== 1'b1 || mem_req !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin tests_failed++; $display("FAIL hlt_hold: core moved with run held, expected halted at step 0"); end
        run = 1'b0;
        tick();
        run = 1'b1;
        expect_mem(1'b0);
        tick();
        tests_run++;
        if (halted !== 1'b0) begin tests_failed++; $display("FAIL hlt_restart: halted=%0b, expected 0", halted); end
        run_until_halt(0, 6, "hlt_rehalt_tick");
        check_drained("hlt");
        run = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int   t = 0;
        logic mid = 1'b1;
        ack_delay = 1;
        data_in = 8'h05;
        alu_flag = 3'b010;
        expect_mem(1'b0);
        expect_ir(8'h05);
        expect_flag(3'b010);
        expect_mem(1'b0);
        expect_ir(8'h06);
        run = 1'b1;
        do begin
            tick();
            t++;
            if (instruction === 8'h05) data_in = 8'h06;
            if (t == 7) mid = halted;
            if (t == 10) run = 1'b0;
        end while (!halted && t < 100);
        tests_run += 2;
        if (mid !== 1'b0) begin tests_failed++; $display("FAIL b2b_continue: halted=%0b between instructions, expected 0", mid); end
        if (t != 13) begin tests_failed++; $display("FAIL b2b_halt_tick: %0d cycles, expected 13", t); end
        check_drained("b2b");
    endtask

    task automatic test_overrun();
        int         t = 0;
        logic       ill_before = 1'b1;
        logic [3:0] st_before = 4'd0;
        never_end = 1'b1;
        data_in = model_ir;
        run = 1'b1;
        do begin
            tick();
            t++;
            if (t == 16) begin
                ill_before = illegal;
                st_before = state;
            end
        end while (!halted && t < 100);
        tests_run += 4;
        if (t != 17) begin tests_failed++; $display("FAIL overrun_tick: halted after %0d, expected 17", t); end
        if (ill_before !== 1'b0 || st_before !== 4'd15) begin
            tests_failed++;
            $display("FAIL overrun_pre: illegal=%0b state=%0d, expected 0/15", ill_before, st_before);
        end
        if (illegal !== 1'b1) begin tests_failed++; $display("FAIL overrun_illegal: %0b, expected 1", illegal); end
        if (state !== 4'd0) begin tests_failed++; $display("FAIL overrun_state: %0d, expected 0", state); end
        never_end = 1'b0;
        run = 1'b0;
        tick();
        ack_delay = 1;
        expect_mem(1'b0);
        run = 1'b1;
        run_until_halt(2, 7, "overrun_rerun_tick");
        tests_run++;
        if (illegal !== 1'b1) begin tests_failed++; $display("FAIL overrun_sticky: %0b, expected 1", illegal); end
        check_drained("overrun");
    endtask

    task automatic test_step();
        logic bad = 1'b0;
        test_reset();
        ack_delay = 1;
        data_in = 8'h33;
        run = 1'b0;
`ifdef CTRL_SEQ_STEP_EN
        expect_mem(1'b0);
        expect_ir(8'h33);
        step = 1'b1;
        tick();
        step = 1'b0;
        run_until_halt(0, 6, "step_halt_tick");
        data_in = 8'h34;
        expect_mem(1'b0);
        expect_ir(8'h34);
        step = 1'b1;
        run = 1'b1;
        tick();
        step = 1'b0;
        run_until_halt(0, 6, "step_run_halt_tick");
        repeat (4) begin
            tick();
            if (halted !== 1'b1 || state !== 4'd0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin tests_failed++; $display("FAIL step_stays_halted: core restarted, expected halted"); end
        run = 1'b0;
`else
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (10) begin
            tick();
            if (halted !== 1'b1 || state !== 4'd0 || mem_req !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin tests_failed++; $display("FAIL step_ignored: core moved on step, expected no change"); end
`endif
        check_drained("step");
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_run_drop();
        test_hlt();
        test_back_to_back();
        test_overrun();
        test_step();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
